// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between the icache (A, read-only) and the
// dcache (B, read/write); ties are broken round-robin against the last grant.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read_a,
  input  logic [ADDR_WIDTH-1:0] pmem_addr_a,
  output logic [LINE_WIDTH-1:0] pmem_rdata_a,
  output logic                  pmem_resp_a,
  input  logic                  pmem_read_b,
  input  logic                  pmem_write_b,
  input  logic [ADDR_WIDTH-1:0] pmem_address_b,
  input  logic [LINE_WIDTH-1:0] pmem_wdata_b,
  output logic [LINE_WIDTH-1:0] pmem_rdata_b,
  output logic                  pmem_resp_b,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_e;
  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  state_e                  state_q;
  grant_e                  last_grant_q;
  logic                    read_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;

  always_comb begin
    req_a   = pmem_read_a;
    req_b   = pmem_read_b | pmem_write_b;
    grant_a = req_a && (!req_b || last_grant_q == GRANT_B);
    grant_b = req_b && !grant_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_A;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_a) begin
            state_q      <= SERVE_A;
            last_grant_q <= GRANT_A;
            read_q       <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= pmem_addr_a;
            wdata_q      <= '0;
          end else if (grant_b) begin
            // A simultaneous read+write on B is a writeback ahead of refill.
            state_q      <= SERVE_B;
            last_grant_q <= GRANT_B;
            read_q       <= !pmem_write_b;
            write_q      <= pmem_write_b;
            addr_q       <= pmem_address_b;
            wdata_q      <= pmem_wdata_b;
          end
        end
        SERVE_A, SERVE_B: begin
          if (pmem_resp) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_resp_a  = pmem_resp && (state_q == SERVE_A);
  assign pmem_resp_b  = pmem_resp && (state_q == SERVE_B);
  assign pmem_rdata_a = pmem_rdata;
  assign pmem_rdata_b = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: table of single transactions plus
// hand-written tie, drop-request and reset-abort sequences.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read_a;
  logic [31:0]  pmem_addr_a;
  logic [255:0] pmem_rdata_a;
  logic         pmem_resp_a;
  logic         pmem_read_b;
  logic         pmem_write_b;
  logic [31:0]  pmem_address_b;
  logic [255:0] pmem_wdata_b;
  logic [255:0] pmem_rdata_b;
  logic         pmem_resp_b;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .pmem_read_a(pmem_read_a), .pmem_addr_a(pmem_addr_a),
    .pmem_rdata_a(pmem_rdata_a), .pmem_resp_a(pmem_resp_a),
    .pmem_read_b(pmem_read_b), .pmem_write_b(pmem_write_b),
    .pmem_address_b(pmem_address_b), .pmem_wdata_b(pmem_wdata_b),
    .pmem_rdata_b(pmem_rdata_b), .pmem_resp_b(pmem_resp_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ra;
    logic [31:0]  aa;
    logic         rb;
    logic         wb;
    logic [31:0]  ab;
    logic [255:0] wd;
    logic [255:0] rd;
    int           lat;
    logic         exp_b;
    logic         exp_w;
    logic [31:0]  exp_addr;
    logic [255:0] exp_wd;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  vec_t e;
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic ra, logic [31:0] aa, logic rb, logic wb,
                              logic [31:0] ab, logic [255:0] wd, logic [255:0] rd,
                              int lat, logic exp_b, logic exp_w,
                              logic [31:0] exp_addr, logic [255:0] exp_wd);
    vec_t v;
    v.ra = ra; v.aa = aa; v.rb = rb; v.wb = wb; v.ab = ab; v.wd = wd; v.rd = rd;
    v.lat = lat; v.exp_b = exp_b; v.exp_w = exp_w;
    v.exp_addr = exp_addr; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    pmem_read_a    = v.ra;
    pmem_addr_a    = v.aa;
    pmem_read_b    = v.rb;
    pmem_write_b   = v.wb;
    pmem_address_b = v.ab;
    pmem_wdata_b   = v.wd;
    sb.push_back(v);
  endtask

  task automatic release_reqs();
    pmem_read_a  = 1'b0;
    pmem_read_b  = 1'b0;
    pmem_write_b = 1'b0;
  endtask

  // Returns at the negedge where a strobe is first seen; checks it took exp_n negedges.
  task automatic wait_strobe(input string name, input int exp_n);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        chk(name, n, exp_n);
        return;
      end
    end
    chk({name, "_timeout"}, 9, exp_n);
  endtask

  task automatic pop_exp(output vec_t v);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      v = mk(0, 0, 0, 0, 0, '0, '0, 0, 0, 0, 0, '0);
    end else begin
      v = sb.pop_front();
    end
  endtask

  task automatic serve(input vec_t v, input bit rel);
    chk("strobe", {pmem_read, pmem_write}, {!v.exp_w, v.exp_w});
    chk("addr", pmem_address, v.exp_addr);
    chk("wdata", pmem_wdata, v.exp_wd);
    chk("owner_b", {pmem_resp_a, pmem_resp_b}, 2'b00);
    for (int i = 0; i < v.lat; i++) begin
      @(posedge clk); #1;
      chk("hold_strobe", {pmem_read, pmem_write}, {!v.exp_w, v.exp_w});
      chk("hold_addr", pmem_address, v.exp_addr);
    end
    pmem_rdata = v.rd;
    pmem_resp  = 1'b1;
    #1;
    chk("resp_ab", {pmem_resp_a, pmem_resp_b}, {!v.exp_b, v.exp_b});
    chk("rdata_a", pmem_rdata_a, v.rd);
    chk("rdata_b", pmem_rdata_b, v.rd);
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    if (rel) release_reqs();
    chk("resp_pulse", {pmem_resp_a, pmem_resp_b}, 2'b00);
    @(negedge clk);
    chk("strobe_clear", {pmem_read, pmem_write}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1, 32'h0000_1040, 0, 0, 32'h0, '0, {32{8'hA5}}, 3,
                 0, 0, 32'h0000_1040, '0);
    vecs[1] = mk(0, 32'h0, 0, 1, 32'h0000_2000, {8{32'h1234_5678}}, '0, 2,
                 1, 1, 32'h0000_2000, {8{32'h1234_5678}});
    vecs[2] = mk(0, 32'h0, 1, 0, 32'h0000_3000, {8{32'h0BAD_F00D}}, {8{32'h600D_CAFE}}, 0,
                 1, 0, 32'h0000_3000, {8{32'h0BAD_F00D}});
    vecs[3] = mk(0, 32'h0, 1, 1, 32'h0000_3100, {8{32'hFEED_BEEF}}, {8{32'h1111_2222}}, 1,
                 1, 1, 32'h0000_3100, {8{32'hFEED_BEEF}});
    vecs[4] = mk(1, 32'h0000_7FC0, 0, 0, 32'h0000_9999, {8{32'h55AA_55AA}}, {8{32'h0123_4567}}, 0,
                 0, 0, 32'h0000_7FC0, '0);
    vecs[5] = mk(1, 32'hFFFF_FFC0, 0, 0, 32'h0, '0, '1, 5,
                 0, 0, 32'hFFFF_FFC0, '0);

    rst = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = {8{32'hC0DE_0001}};
    release_reqs();
    pmem_addr_a = '0; pmem_address_b = '0; pmem_wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_resp", {pmem_resp_a, pmem_resp_b}, 2'b00);
    chk("rst_rdata_a", pmem_rdata_a, {8{32'hC0DE_0001}});
    chk("rst_rdata_b", pmem_rdata_b, {8{32'hC0DE_0001}});
    rst = 1'b0;
    pmem_rdata = '0;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      wait_strobe("grant_latency", 2);
      pop_exp(e);
      serve(e, 1);
    end

    // Requester drops its request and changes address mid-transaction.
    @(posedge clk); #1;
    drive(mk(1, 32'h0000_1040, 0, 0, 32'h0, '0, {8{32'hABCD_0123}}, 2,
             0, 0, 32'h0000_1040, '0));
    wait_strobe("drop_grant", 2);
    pop_exp(e);
    @(posedge clk); #1;
    pmem_read_a = 1'b0;
    pmem_addr_a = 32'hDEAD_0000;
    serve(e, 1);

    // Reset during SERVE_B, then a stale response while idle.
    @(posedge clk); #1;
    pmem_read_b = 1'b1; pmem_address_b = 32'h0000_6000; pmem_wdata_b = {8{32'h7777_8888}};
    wait_strobe("rstmid_grant", 2);
    chk("rstmid_read", pmem_read, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    release_reqs();
    chk("rstmid_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("rstmid_addr", pmem_address, 0);
    chk("rstmid_wdata", pmem_wdata, 0);
    pmem_resp = 1'b1;
    #1;
    chk("stale_resp", {pmem_resp_a, pmem_resp_b}, 2'b00);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("stale_no_strobe", {pmem_read, pmem_write}, 2'b00);

    // Both ports held after reset: grant order B, A, B with one idle strobe cycle between.
    @(posedge clk); #1;
    pmem_read_a = 1'b1; pmem_addr_a = 32'h0000_4000;
    pmem_read_b = 1'b1; pmem_address_b = 32'h0000_5000; pmem_wdata_b = {8{32'hCAFE_F00D}};
    sb.push_back(mk(1, 32'h0000_4000, 1, 0, 32'h0000_5000, {8{32'hCAFE_F00D}}, {8{32'hB0B0_0001}}, 1,
                    1, 0, 32'h0000_5000, {8{32'hCAFE_F00D}}));
    sb.push_back(mk(1, 32'h0000_4000, 1, 0, 32'h0000_5000, {8{32'hCAFE_F00D}}, {8{32'hA0A0_0002}}, 0,
                    0, 0, 32'h0000_4000, '0));
    sb.push_back(mk(1, 32'h0000_4000, 1, 0, 32'h0000_5000, {8{32'hCAFE_F00D}}, {8{32'hB0B0_0003}}, 2,
                    1, 0, 32'h0000_5000, {8{32'hCAFE_F00D}}));
    wait_strobe("tie_first", 2);
    pop_exp(e);
    serve(e, 0);
    wait_strobe("tie_second", 1);
    pop_exp(e);
    serve(e, 0);
    wait_strobe("tie_third", 1);
    pop_exp(e);
    serve(e, 1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares one physical-memory line interface between the instruction cache (port A, read-only) and the data cache (port B, read/write). It sits between the two cache instances and the line-wide memory or cacheline adaptor. Each cache sees a private `pmem_*` interface. The arbiter serialises their line transactions, latches the winning request, and forwards the response to the requester that owns it. Ties are broken round-robin so neither cache can starve.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports.
- `LINE_WIDTH`, 256, cache-line width on all data ports.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pmem_read_a`  in  1  icache line-read request; held until `pmem_resp_a`.
- `pmem_addr_a`  in  ADDR_WIDTH  icache line address.
- `pmem_rdata_a`  out  LINE_WIDTH  line data to the icache.
- `pmem_resp_a`  out  1  one-cycle completion pulse to the icache.
- `pmem_read_b`  in  1  dcache line-read request; held until `pmem_resp_b`.
- `pmem_write_b`  in  1  dcache line-writeback request; held until `pmem_resp_b`.
- `pmem_address_b`  in  ADDR_WIDTH  dcache line address.
- `pmem_wdata_b`  in  LINE_WIDTH  dcache writeback line.
- `pmem_rdata_b`  out  LINE_WIDTH  line data to the dcache.
- `pmem_resp_b`  out  1  one-cycle completion pulse to the dcache.
- `pmem_read`  out  1  downstream read strobe (registered).
- `pmem_write`  out  1  downstream write strobe (registered).
- `pmem_address`  out  ADDR_WIDTH  downstream address (registered).
- `pmem_wdata`  out  LINE_WIDTH  downstream write line (registered).
- `pmem_rdata`  in  LINE_WIDTH  downstream read line.
- `pmem_resp`  in  1  downstream completion pulse.

## Operation
- States: IDLE, SERVE_A, SERVE_B. The `last_grant` register holds A or B.
- Request definitions:
  - `req_a` = `pmem_read_a`.
  - `req_b` = `pmem_read_b | pmem_write_b`.
- Granting in IDLE:
  - Only `req_a`: go to SERVE_A.
  - Only `req_b`: go to SERVE_B.
  - Both: grant the port that is not `last_grant`.
  - Neither: stay in IDLE.
- On a grant, in the same edge:
  - Latch the address into `pmem_address`.
  - Latch `pmem_wdata_b` into `pmem_wdata`; for a port-A grant, load 0.
  - Set the strobe: `pmem_read`=1 for A; for B, `pmem_write`=`pmem_write_b` and `pmem_read`=`!pmem_write_b`.
  - Update `last_grant` to the granted port.
- If `pmem_read_b` and `pmem_write_b` are both high, the write takes precedence (writeback before refill).
- While in SERVE_x:
  - The latched strobe, address and wdata stay constant.
  - Requester inputs are ignored, including a requester that drops its request.
- On `pmem_resp`=1 in SERVE_x:
  - `pmem_resp_x` = 1 combinationally in that cycle.
  - Next state is IDLE; `pmem_read` and `pmem_write` clear on that edge.
- `pmem_resp_a` = `pmem_resp & SERVE_A`; `pmem_resp_b` = `pmem_resp & SERVE_B`.
- `pmem_rdata` is broadcast unmodified to `pmem_rdata_a` and `pmem_rdata_b`.
- A `pmem_resp` that arrives in IDLE is dropped; neither requester sees it.
- `rst`:
  - Next state IDLE; `last_grant`=A, so the first tie after reset goes to B.
  - `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` are cleared to 0.
  - A transaction in flight is abandoned; its `pmem_resp`, if it arrives later, is dropped.
- Reset values of outputs: `pmem_resp_a`=0, `pmem_resp_b`=0, `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0. `pmem_rdata_a` and `pmem_rdata_b` follow `pmem_rdata`.

## Timing
- Request seen in IDLE in cycle N: grant on the edge ending N; downstream strobe high from cycle N+1.
- Response:
  - `pmem_resp` in cycle M gives `pmem_resp_x` in cycle M (zero added latency on the return path).
  - The strobe is low from cycle M+1.
- Turnaround:
  - IDLE occupies cycle M+1; the next grant is on the edge ending M+1.
  - The earliest next strobe is cycle M+2, so back-to-back transactions are separated by exactly one idle strobe cycle.
- Added latency versus a direct connection: 1 cycle before the request, 0 on the response, 1 idle cycle after.
- The downstream may assert `pmem_resp` as early as cycle N+1, the first strobe cycle; the arbiter handles this.

## Test plan
- **Single icache read:**
  - Stimulus: `pmem_read_a`=1, `pmem_addr_a`=0x0000_1040; memory responds 3 cycles later with line 0xA5…A5.
  - Response: `pmem_read`=1 and `pmem_address`=0x0000_1040 from cycle N+1; `pmem_resp_a` pulses once with data 0xA5…A5; `pmem_resp_b` stays 0.
- **Dcache writeback:**
  - Stimulus: `pmem_write_b`=1, `pmem_address_b`=0x0000_2000, `pmem_wdata_b`=0x1234…
  - Response: `pmem_write`=1, `pmem_read`=0, address and wdata forwarded unchanged; a single `pmem_resp_b` pulse.
- **Simultaneous requests after reset, held for three transactions:**
  - Stimulus: A and B both request, held.
  - Response: grant order B, A, B; one idle strobe cycle between each transaction.
- **Requester drops request mid-transaction:**
  - Stimulus: A is granted; `pmem_read_a` falls at N+2; `pmem_addr_a` changes to 0xDEAD_0000.
  - Response: strobe and address stay 0x0000_1040 until `pmem_resp`; `pmem_resp_a` still pulses.
- **Reset mid-transaction:**
  - Stimulus: `rst` asserted during SERVE_B; stale `pmem_resp` arrives after reset.
  - Response: strobes 0 the cycle after `rst`; stale resp forwarded to neither port.
- **Illegal read-and-write on B:**
  - Stimulus: `pmem_read_b`=`pmem_write_b`=1.
  - Response: `pmem_write`=1, `pmem_read`=0.
